id_operand_stage: RTL and testbench
===================================

// Module: id_operand_stage
// PURPOSE
//  Parametrised ID-stage front end for the 5-stage MIPS core. Holds the IF->ID pipeline register and buffers
//  the sync-SRAM instruction word across stalls. Resolves rs/rt operands through NUM_FWD priority-ordered
//  forwarding ports. Raises a load-use stall request and counts load-use stall cycles. The decoder consumes id_inst/src1/src2.
// PARAMETERS
//  DATA_W   32  operand / forwarded data width
//  PC_W     32  program counter width
//  ADDR_W    5  register address width; address 0 is hard-wired zero
//  NUM_FWD   3  forwarding sources; index 0 = youngest (EX), highest priority
//  CNT_W    32  width of load-use stall counter (saturating)
// PORTS
//  clk         in   1                clock, all state on rising edge
//  resetn      in   1                asynchronous active-low reset
//  id_hold     in   1                ID stalled this cycle: keep register and buffer contents
//  id_flush    in   1                kill ID contents (branch/exception); priority over id_hold
//  if_valid    in   1                IF presents a valid pc this cycle
//  if_pc       in   PC_W             pc of instruction entering ID
//  inst_rdata  in   32               sync-SRAM data for the pc latched last cycle
//  use_rs      in   1                decoder: instruction reads rs
//  use_rt      in   1                decoder: instruction reads rt
//  rf_raddr1   out  ADDR_W           = id_inst[25:21]
//  rf_raddr2   out  ADDR_W           = id_inst[20:16]
//  rf_rdata1   in   DATA_W           regfile read data port 1
//  rf_rdata2   in   DATA_W           regfile read data port 2
//  fwd_we      in   NUM_FWD          source i will write the regfile
//  fwd_waddr   in   NUM_FWD*ADDR_W   dest of source i, slice [i*ADDR_W +: ADDR_W]
//  fwd_wdata   in   NUM_FWD*DATA_W   result of source i (don't-care if fwd_ld[i])
//  fwd_ld      in   NUM_FWD          source i is a load whose data is not yet available
//  id_valid    out  1                ID holds a live instruction
//  id_pc       out  PC_W             pc of ID instruction
//  id_inst     out  32               instruction word (buffered while held)
//  src1, src2  out  DATA_W           forwarded rs / rt operands
//  stallreq    out  1                load-use hazard; combinational
//  ldstall_cnt out  CNT_W            saturating count of cycles with stallreq=1
// BEHAVIOUR
//  Reset (resetn=0, async): id_valid=0, id_pc=0, buf_valid=0, inst_buf=0, ldstall_cnt=0.
//   With id_valid=0: id_inst=0 and stallreq=0.
//  Pipeline reg, per edge, priority: id_flush -> valid<=0, buf_valid<=0; id_hold -> hold;
//   else valid<=if_valid, pc<=if_pc, buf_valid<=0.
//  Inst buffer: 1 cycle of latency from pc to word. First held cycle with buf_valid=0 -> inst_buf<=inst_rdata,
//   buf_valid<=1. id_inst = !id_valid ? 0 : buf_valid ? inst_buf : inst_rdata. Word is stable for whole stall.
//  Forwarding, per operand, addr a: if a==0 -> 0. Else the lowest i with fwd_we[i] && waddr_i==a wins
//   -> fwd_wdata[i]. No match -> rf_rdata. Simultaneous matches: lowest index only. Regfile writes are
//   not bypassed internally, so the WB source must be a forwarding port.
//  stallreq = id_valid & ((use_rs & hit_rs & ld_rs) | (use_rt & hit_rt & ld_rt)). ld_x is fwd_ld of the
//   winning source only; an older load shadowed by a younger non-load match does not stall.
//  Environment contract: stallreq drives id_hold (and bubbles EX) externally. This block never holds itself.
//  ldstall_cnt: +1 per cycle with stallreq=1, saturates at all-ones, never wraps. Cleared only by reset.
//  Flush with hold in the same cycle: flush wins, buffer is invalidated, and the next unheld edge loads IF.
//  Reset mid-stall: all state cleared. There is no pending stall after reset.
// STRUCTURE
//  Shared package (lib/defines.vh): ADDR_W, DATA_W, NUM_FWD defaults, field slice
//   constants RS_LO/RT_LO, fwd bus width macro FWD_WD(n).
//  Sub-module fwd_mux (#DATA_W,ADDR_W,NUM_FWD): addr, rf_data, fwd buses -> data, hit, ld.
//   Instantiated twice (rs, rt). Pipeline register and buffer stay in the parent.
// TESTING
//  1 reset: drive resetn=0 mid-run -> id_valid=0, id_inst=0, stallreq=0, ldstall_cnt=0 immediately.
//  2 hold buffer: load pc=0x100, then word 0x3C011234 arrives, hold 3 cycles, SRAM data changes to 0xDEADBEEF
//    -> id_inst stays 0x3C011234 for all 3 cycles; after release, the next pc loads.
//  3 priority: rs=5, src0 & src2 both write r5 (0xAAAA / 0xBBBB), rf=0x1111 -> src1=0xAAAA.
//    Drop src0 -> 0xBBBB. Drop both -> 0x1111.
//  4 zero reg: rt=0, fwd_we[0]=1, waddr=0, wdata=0xFFFF_FFFF -> src2=0, no stall.
//  5 load-use: src0 load to r8, inst uses rs=8 -> stallreq=1, cnt=1. Same with use_rs=0 -> stallreq=0.
//    Younger non-load src0 to r8 plus load src1 to r8 -> stallreq=0.
//  6 flush+hold: assert both with buf_valid=1 -> next cycle id_valid=0, buf_valid=0; CNT_W=2 with 5 stall cycles -> cnt=3.

Source files
------------

// File: rtl/id_operand_stage_pkg.sv
// Shared constants for the ID operand stage: parameter defaults, instruction field
// positions and the forwarding bus width helper.
package id_operand_stage_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int PC_W_DEF    = 32;
    localparam int ADDR_W_DEF  = 5;
    localparam int NUM_FWD_DEF = 3;
    localparam int CNT_W_DEF   = 32;
    localparam int INST_W      = 32;
    localparam int RS_LO       = 21;
    localparam int RT_LO       = 16;

    function automatic int fwd_wd(input int n, input int w);
        return n * w;
    endfunction

endpackage

// File: rtl/id_operand_stage_fwd_mux.sv
// Operand forwarding mux: picks the youngest matching in-flight result, falls back to
// the register file, and reports whether the winner is a load still waiting for data.
module id_operand_stage_fwd_mux
    import id_operand_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_FWD = NUM_FWD_DEF
) (
    input  logic [ADDR_W-1:0]                      addr,
    input  logic [DATA_W-1:0]                      rf_data,
    input  logic [NUM_FWD-1:0]                     fwd_we,
    input  logic [fwd_wd(NUM_FWD, ADDR_W)-1:0]     fwd_waddr,
    input  logic [fwd_wd(NUM_FWD, DATA_W)-1:0]     fwd_wdata,
    input  logic [NUM_FWD-1:0]                     fwd_ld,
    output logic [DATA_W-1:0]                      data,
    output logic                                   hit,
    output logic                                   ld
);

    // Scan oldest to youngest so the lowest index overwrites any older match.
    always_comb begin
        data = rf_data;
        hit  = 1'b0;
        ld   = 1'b0;
        if (addr == {ADDR_W{1'b0}}) begin
            data = {DATA_W{1'b0}};
        end else begin
            for (int i = NUM_FWD - 1; i >= 0; i--) begin
                if (fwd_we[i] && (fwd_waddr[i*ADDR_W +: ADDR_W] == addr)) begin
                    data = fwd_wdata[i*DATA_W +: DATA_W];
                    hit  = 1'b1;
                    ld   = fwd_ld[i];
                end else begin
                end
            end
        end
    end

endmodule

// File: rtl/id_operand_stage.sv
// ID-stage front end: IF->ID pipeline register, instruction word buffer for stalls,
// rs/rt operand forwarding, load-use stall request and a saturating stall counter.
module id_operand_stage
    import id_operand_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PC_W    = PC_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_FWD = NUM_FWD_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                id_hold,
    input  logic                                id_flush,
    input  logic                                if_valid,
    input  logic [PC_W-1:0]                     if_pc,
    input  logic [INST_W-1:0]                   inst_rdata,
    input  logic                                use_rs,
    input  logic                                use_rt,
    output logic [ADDR_W-1:0]                   rf_raddr1,
    output logic [ADDR_W-1:0]                   rf_raddr2,
    input  logic [DATA_W-1:0]                   rf_rdata1,
    input  logic [DATA_W-1:0]                   rf_rdata2,
    input  logic [NUM_FWD-1:0]                  fwd_we,
    input  logic [fwd_wd(NUM_FWD, ADDR_W)-1:0]  fwd_waddr,
    input  logic [fwd_wd(NUM_FWD, DATA_W)-1:0]  fwd_wdata,
    input  logic [NUM_FWD-1:0]                  fwd_ld,
    output logic                                id_valid,
    output logic [PC_W-1:0]                     id_pc,
    output logic [INST_W-1:0]                   id_inst,
    output logic [DATA_W-1:0]                   src1,
    output logic [DATA_W-1:0]                   src2,
    output logic                                stallreq,
    output logic [CNT_W-1:0]                    ldstall_cnt
);

    logic                valid_r;
    logic [PC_W-1:0]     pc_r;
    logic                buf_valid_r;
    logic [INST_W-1:0]   inst_buf_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [INST_W-1:0]   inst_s;
    logic                hit_rs_s, hit_rt_s, ld_rs_s, ld_rt_s;
    logic                stall_s;

    // Pipeline register and instruction buffer; flush beats hold.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_r     <= 1'b0;
            pc_r        <= {PC_W{1'b0}};
            buf_valid_r <= 1'b0;
            inst_buf_r  <= {INST_W{1'b0}};
        end else if (id_flush) begin
            valid_r     <= 1'b0;
            buf_valid_r <= 1'b0;
        end else if (id_hold) begin
            // SRAM word is only valid the cycle after the pc; capture it once per stall.
            if (!buf_valid_r) begin
                inst_buf_r  <= inst_rdata;
                buf_valid_r <= 1'b1;
            end else begin
                inst_buf_r  <= inst_buf_r;
                buf_valid_r <= buf_valid_r;
            end
        end else begin
            valid_r     <= if_valid;
            pc_r        <= if_pc;
            buf_valid_r <= 1'b0;
        end
    end

    // Select the buffered word while stalled, otherwise the live SRAM output.
    always_comb begin
        inst_s = {INST_W{1'b0}};
        if (!valid_r) begin
            inst_s = {INST_W{1'b0}};
        end else if (buf_valid_r) begin
            inst_s = inst_buf_r;
        end else begin
            inst_s = inst_rdata;
        end
    end

    assign id_inst   = inst_s;
    assign id_valid  = valid_r;
    assign id_pc     = pc_r;
    assign rf_raddr1 = inst_s[RS_LO +: ADDR_W];
    assign rf_raddr2 = inst_s[RT_LO +: ADDR_W];

    id_operand_stage_fwd_mux #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD)
    ) u_fwd_rs (
        .addr(rf_raddr1), .rf_data(rf_rdata1), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
        .fwd_wdata(fwd_wdata), .fwd_ld(fwd_ld), .data(src1), .hit(hit_rs_s), .ld(ld_rs_s)
    );

    id_operand_stage_fwd_mux #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD)
    ) u_fwd_rt (
        .addr(rf_raddr2), .rf_data(rf_rdata2), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
        .fwd_wdata(fwd_wdata), .fwd_ld(fwd_ld), .data(src2), .hit(hit_rt_s), .ld(ld_rt_s)
    );

    assign stall_s  = valid_r & ((use_rs & hit_rs_s & ld_rs_s) | (use_rt & hit_rt_s & ld_rt_s));
    assign stallreq = stall_s;

    // Load-use stall cycle counter, saturating at all-ones.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign ldstall_cnt = cnt_r;

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: scenario tasks with a scoreboard queue of
// expected values; a second instance with CNT_W=2 checks counter saturation.
module tb_id_operand_stage;

    logic        clk = 1'b0;
    logic        resetn, id_hold, id_flush, if_valid, use_rs, use_rt;
    logic [31:0] if_pc, inst_rdata, rf_rdata1, rf_rdata2;
    logic [2:0]  fwd_we, fwd_ld;
    logic [14:0] fwd_waddr;
    logic [95:0] fwd_wdata;

    logic [4:0]  rf_raddr1, rf_raddr2, rf_raddr1_b, rf_raddr2_b;
    logic        id_valid, stallreq, id_valid_b, stallreq_b;
    logic [31:0] id_pc, id_inst, src1, src2, ldstall_cnt;
    logic [31:0] id_pc_b, id_inst_b, src1_b, src2_b;
    logic [1:0]  cnt2;

    logic [31:0] exp_q[$];
    logic [31:0] e;
    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    id_operand_stage dut (
        .clk(clk), .resetn(resetn), .id_hold(id_hold), .id_flush(id_flush),
        .if_valid(if_valid), .if_pc(if_pc), .inst_rdata(inst_rdata),
        .use_rs(use_rs), .use_rt(use_rt), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
        .fwd_wdata(fwd_wdata), .fwd_ld(fwd_ld), .id_valid(id_valid), .id_pc(id_pc),
        .id_inst(id_inst), .src1(src1), .src2(src2), .stallreq(stallreq),
        .ldstall_cnt(ldstall_cnt)
    );

    id_operand_stage #(.CNT_W(2)) dut2 (
        .clk(clk), .resetn(resetn), .id_hold(id_hold), .id_flush(id_flush),
        .if_valid(if_valid), .if_pc(if_pc), .inst_rdata(inst_rdata),
        .use_rs(use_rs), .use_rt(use_rt), .rf_raddr1(rf_raddr1_b), .rf_raddr2(rf_raddr2_b),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
        .fwd_wdata(fwd_wdata), .fwd_ld(fwd_ld), .id_valid(id_valid_b), .id_pc(id_pc_b),
        .id_inst(id_inst_b), .src1(src1_b), .src2(src2_b), .stallreq(stallreq_b),
        .ldstall_cnt(cnt2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_fwd(input int i, input logic we, input logic [4:0] a,
                           input logic [31:0] d, input logic ld);
        fwd_we[i] = we;
        fwd_waddr[i*5 +: 5] = a;
        fwd_wdata[i*32 +: 32] = d;
        fwd_ld[i] = ld;
    endtask

    task automatic clear_all;
        id_hold = 1'b0; id_flush = 1'b0; if_valid = 1'b0; if_pc = 32'h0;
        use_rs = 1'b0; use_rt = 1'b0; rf_rdata1 = 32'h0; rf_rdata2 = 32'h0;
        fwd_we = 3'b000; fwd_ld = 3'b000; fwd_waddr = 15'h0; fwd_wdata = 96'h0;
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
        #1;
    endtask

    // Bring pc into ID, then present its SRAM word and hold it there.
    task automatic load_inst(input logic [31:0] pc, input logic [31:0] word);
        if_valid = 1'b1; if_pc = pc; id_hold = 1'b0; id_flush = 1'b0;
        tick;
        if_valid = 1'b0; id_hold = 1'b1; inst_rdata = word;
        #1;
    endtask

    task automatic test_reset;
        inst_rdata = 32'h1234_5678;
        #1;
        if (id_valid !== 1'b0) begin $display("FAIL reset_valid: got %b expected 0", id_valid); fail_cnt++; end else pass_cnt++; total_cnt++;
        if (id_inst !== 32'h0) begin $display("FAIL reset_inst: got %h expected 0", id_inst); fail_cnt++; end else pass_cnt++; total_cnt++;
        load_inst(32'h40, 32'h0100_0000);
        set_fwd(0, 1'b1, 5'd8, 32'h0, 1'b1);
        use_rs = 1'b1;
        tick; tick;
        if (ldstall_cnt !== 32'd2) begin $display("FAIL pre_reset_cnt: got %0d expected 2", ldstall_cnt); fail_cnt++; end else pass_cnt++; total_cnt++;
        #1 resetn = 1'b0;
        #1;
        if (id_valid !== 1'b0) begin $display("FAIL midreset_valid: got %b expected 0", id_valid); fail_cnt++; end else pass_cnt++; total_cnt++;
        if (id_inst !== 32'h0) begin $display("FAIL midreset_inst: got %h expected 0", id_inst); fail_cnt++; end else pass_cnt++; total_cnt++;
        if (stallreq !== 1'b0) begin $display("FAIL midreset_stall: got %b expected 0", stallreq); fail_cnt++; end else pass_cnt++; total_cnt++;
        if (ldstall_cnt !== 32'd0) begin $display("FAIL midreset_cnt: got %0d expected 0", ldstall_cnt); fail_cnt++; end else pass_cnt++; total_cnt++;
        resetn = 1'b1;
        clear_all;
        tick;
    endtask

    task automatic test_hold_buffer;
        load_inst(32'h100, 32'h3C01_1234);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(32'h3C01_1234);
            e = exp_q.pop_front();
            if (id_inst !== e) begin $display("FAIL hold_inst[%0d]: got %h expected %h", k, id_inst, e); fail_cnt++; end else pass_cnt++; total_cnt++;
            if (id_pc !== 32'h100) begin $display("FAIL hold_pc[%0d]: got %h expected 100", k, id_pc); fail_cnt++; end else pass_cnt++; total_cnt++;
            tick;
            inst_rdata = 32'hDEAD_BEEF;
            #1;
        end
        id_hold = 1'b0; if_valid = 1'b1; if_pc = 32'h104;
        exp_q.push_back(32'h104);
        tick;
        id_hold = 1'b1; if_valid = 1'b0;
        #1;
        e = exp_q.pop_front();
        if (id_pc !== e) begin $display("FAIL release_pc: got %h expected %h", id_pc, e); fail_cnt++; end else pass_cnt++; total_cnt++;
        if (id_inst !== 32'hDEAD_BEEF) begin $display("FAIL release_inst: got %h expected deadbeef", id_inst); fail_cnt++; end else pass_cnt++; total_cnt++;
        clear_all;
    endtask

    task automatic test_priority;
        load_inst(32'h200, 32'h00A0_0000);
        use_rs = 1'b1; rf_rdata1 = 32'h1111;
        set_fwd(0, 1'b1, 5'd5, 32'hAAAA, 1'b0);
        set_fwd(2, 1'b1, 5'd5, 32'hBBBB, 1'b0);
        #1;
        if (rf_raddr1 !== 5'd5) begin $display("FAIL raddr1: got %0d expected 5", rf_raddr1); fail_cnt++; end else pass_cnt++; total_cnt++;
        exp_q.push_back(32'hAAAA);
        e = exp_q.pop_front();
        if (src1 !== e) begin $display("FAIL prio_both: got %h expected %h", src1, e); fail_cnt++; end else pass_cnt++; total_cnt++;
        set_fwd(0, 1'b0, 5'd5, 32'hAAAA, 1'b0);
        exp_q.push_back(32'hBBBB);
        #1;
        e = exp_q.pop_front();
        if (src1 !== e) begin $display("FAIL prio_src2: got %h expected %h", src1, e); fail_cnt++; end else pass_cnt++; total_cnt++;
        set_fwd(2, 1'b0, 5'd5, 32'hBBBB, 1'b0);
        exp_q.push_back(32'h1111);
        #1;
        e = exp_q.pop_front();
        if (src1 !== e) begin $display("FAIL prio_rf: got %h expected %h", src1, e); fail_cnt++; end else pass_cnt++; total_cnt++;
        clear_all;
    endtask

    task automatic test_zero_reg;
        load_inst(32'h300, 32'h0000_0000);
        use_rt = 1'b1; rf_rdata2 = 32'h1234;
        set_fwd(0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1);
        #1;
        if (src2 !== 32'h0) begin $display("FAIL zero_src2: got %h expected 0", src2); fail_cnt++; end else pass_cnt++; total_cnt++;
        if (stallreq !== 1'b0) begin $display("FAIL zero_stall: got %b expected 0", stallreq); fail_cnt++; end else pass_cnt++; total_cnt++;
        clear_all;
    endtask

    task automatic test_load_use;
        do_reset;
        load_inst(32'h400, 32'h0100_0000);
        set_fwd(0, 1'b1, 5'd8, 32'h0, 1'b1);
        use_rs = 1'b1;
        #1;
        if (stallreq !== 1'b1) begin $display("FAIL lu_stall: got %b expected 1", stallreq); fail_cnt++; end else pass_cnt++; total_cnt++;
        tick;
        if (ldstall_cnt !== 32'd1) begin $display("FAIL lu_cnt: got %0d expected 1", ldstall_cnt); fail_cnt++; end else pass_cnt++; total_cnt++;
        use_rs = 1'b0;
        #1;
        if (stallreq !== 1'b0) begin $display("FAIL lu_unused: got %b expected 0", stallreq); fail_cnt++; end else pass_cnt++; total_cnt++;
        tick;
        use_rs = 1'b1;
        set_fwd(0, 1'b1, 5'd8, 32'h77, 1'b0);
        set_fwd(1, 1'b1, 5'd8, 32'h0, 1'b1);
        #1;
        if (stallreq !== 1'b0) begin $display("FAIL lu_shadow: got %b expected 0", stallreq); fail_cnt++; end else pass_cnt++; total_cnt++;
        if (src1 !== 32'h77) begin $display("FAIL lu_shadow_src1: got %h expected 77", src1); fail_cnt++; end else pass_cnt++; total_cnt++;
        tick;
        if (ldstall_cnt !== 32'd1) begin $display("FAIL lu_cnt_final: got %0d expected 1", ldstall_cnt); fail_cnt++; end else pass_cnt++; total_cnt++;
        clear_all;
    endtask

    task automatic test_flush_hold;
        do_reset;
        load_inst(32'h500, 32'h1111_1111);
        tick;
        inst_rdata = 32'h2222_2222;
        #1;
        if (id_inst !== 32'h1111_1111) begin $display("FAIL fh_buffered: got %h expected 11111111", id_inst); fail_cnt++; end else pass_cnt++; total_cnt++;
        id_flush = 1'b1;
        tick;
        if (id_valid !== 1'b0) begin $display("FAIL fh_valid: got %b expected 0", id_valid); fail_cnt++; end else pass_cnt++; total_cnt++;
        if (id_inst !== 32'h0) begin $display("FAIL fh_inst: got %h expected 0", id_inst); fail_cnt++; end else pass_cnt++; total_cnt++;
        id_flush = 1'b0; id_hold = 1'b0; if_valid = 1'b1; if_pc = 32'h504;
        tick;
        id_hold = 1'b1; if_valid = 1'b0;
        #1;
        if (id_pc !== 32'h504) begin $display("FAIL fh_next_pc: got %h expected 504", id_pc); fail_cnt++; end else pass_cnt++; total_cnt++;
        if (id_inst !== 32'h2222_2222) begin $display("FAIL fh_buf_invalid: got %h expected 22222222", id_inst); fail_cnt++; end else pass_cnt++; total_cnt++;
        load_inst(32'h508, 32'h0100_0000);
        set_fwd(0, 1'b1, 5'd8, 32'h0, 1'b1);
        use_rs = 1'b1;
        repeat (5) tick;
        if (ldstall_cnt !== 32'd5) begin $display("FAIL sat_cnt32: got %0d expected 5", ldstall_cnt); fail_cnt++; end else pass_cnt++; total_cnt++;
        if (cnt2 !== 2'd3) begin $display("FAIL sat_cnt2: got %0d expected 3", cnt2); fail_cnt++; end else pass_cnt++; total_cnt++;
        clear_all;
    endtask

    task automatic test_back_to_back;
        clear_all;
        for (int i = 0; i < 4; i++) begin
            if_valid = 1'b1; if_pc = 32'h600 + 32'(i * 4);
            exp_q.push_back(if_pc);
            tick;
            inst_rdata = 32'hC000_0000 + 32'(i);
            #1;
            e = exp_q.pop_front();
            if (id_pc !== e) begin $display("FAIL b2b_pc[%0d]: got %h expected %h", i, id_pc, e); fail_cnt++; end else pass_cnt++; total_cnt++;
            if (id_inst !== 32'hC000_0000 + 32'(i)) begin $display("FAIL b2b_inst[%0d]: got %h expected %h", i, id_inst, 32'hC000_0000 + 32'(i)); fail_cnt++; end else pass_cnt++; total_cnt++;
        end
        if_valid = 1'b0;
        tick;
        if (id_valid !== 1'b0) begin $display("FAIL bubble_valid: got %b expected 0", id_valid); fail_cnt++; end else pass_cnt++; total_cnt++;
        if (id_inst !== 32'h0) begin $display("FAIL bubble_inst: got %h expected 0", id_inst); fail_cnt++; end else pass_cnt++; total_cnt++;
    endtask

    initial begin
        resetn = 1'b0;
        inst_rdata = 32'h0;
        clear_all;
        tick; tick;
        resetn = 1'b1;
        tick;
        test_reset;
        test_hold_buffer;
        test_priority;
        test_zero_reg;
        test_load_use;
        test_flush_hold;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
